snap_readout_sched: RTL and testbench

//  Periodic snapshot controller for a bank of NCHAN sample-and-hold channels sharing one readout bus.
//  - Counts the sampling period and realigns on sync.
//  - Captures all channels on the same cycle.
//  - Drains the held values one channel per beat over a valid/ready stream.
//  - Sits between the per-channel status/accumulator datapath and the shared register/readout bus.

---
 rtl/snap_readout_sched.sv | 119 +++++++++++
 tb/tb_snap_readout_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/snap_readout_sched.sv
// Periodic snapshot of NCHAN sample-and-hold channels, drained one channel per beat on a valid/ready stream.
// Define SNAP_READOUT_SCHED_LAST_EN to add the dout_last output.
module snap_readout_sched #(
  parameter int NCHAN  = 4,
  parameter int WIDTH  = 8,
  parameter int PERIOD = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sync,
  input  logic                       en,
  input  logic [NCHAN*WIDTH-1:0]     din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(NCHAN)-1:0]   dout_chan,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic                       overrun
`ifdef SNAP_READOUT_SCHED_LAST_EN
  ,
  output logic                       dout_last
`endif
);

  localparam int CW = $clog2(PERIOD);
  localparam int IW = $clog2(NCHAN);
  localparam logic [CW-1:0] CTR_LAST = CW'(PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCHAN - 1);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    ctr_q, ctr_d;
  logic             cap_stb_q, cap_stb_d;
  logic [WIDTH-1:0] hold_q [NCHAN];
  logic [WIDTH-1:0] hold_d [NCHAN];
  logic [IW-1:0]    idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [IW-1:0]    chan_q, chan_d;

  logic cap_acc, hs, hs_last, load;

  assign cap_acc = cap_stb_q && en;
  assign hs      = (state_q == DRAIN) && dout_ready;
  assign hs_last = hs && (idx_q == IDX_LAST);
  // A capture landing on the final beat's handshake chains straight into the next drain.
  assign load    = cap_acc && ((state_q == IDLE) || hs_last);

  always_comb begin
    ctr_d     = (sync || ctr_q == CTR_LAST) ? '0 : ctr_q + 1'b1;
    cap_stb_d = sync || (ctr_q == CTR_LAST);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    hold_d    = hold_q;
    dout_d    = dout_q;
    chan_d    = chan_q;
    if (sync) begin
      state_d   = IDLE;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else if (load) begin
      for (int k = 0; k < NCHAN; k++) hold_d[k] = din[k*WIDTH +: WIDTH];
      idx_d   = '0;
      state_d = DRAIN;
    end else if (state_q == DRAIN) begin
      if (cap_acc) overrun_d = 1'b1;
      if (hs_last)  state_d = IDLE;
      else if (hs)  idx_d   = idx_q + 1'b1;
    end
    // Output registers are loaded from next-state so dout tracks the beat being presented.
    if (state_d == DRAIN) begin
      dout_d = hold_d[idx_d];
      chan_d = idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctr_q     <= '0;
      cap_stb_q <= 1'b0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      dout_q    <= '0;
      chan_q    <= '0;
      for (int k = 0; k < NCHAN; k++) hold_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      cap_stb_q <= cap_stb_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      dout_q    <= dout_d;
      chan_q    <= chan_d;
      for (int k = 0; k < NCHAN; k++) hold_q[k] <= hold_d[k];
    end
  end

  assign dout       = dout_q;
  assign dout_chan  = chan_q;
  assign dout_valid = (state_q == DRAIN);
  assign busy       = (state_q == DRAIN);
  assign overrun    = overrun_q;

`ifdef SNAP_READOUT_SCHED_LAST_EN
  logic last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= (state_d == DRAIN) && (idx_d == IDX_LAST);
  end
  assign dout_last = last_q;
`endif

endmodule

// File: tb/tb_snap_readout_sched.sv
// Directed bench for snap_readout_sched: PERIOD=8 instance driven from a vector table,
// PERIOD=4 instance for back-to-back drains.
module tb_snap_readout_sched;

  localparam logic [31:0] D1 = 32'h44332211;
  localparam logic [31:0] D2 = 32'h88776655;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sync8, en8, rdy8, valid8, busy8, ov8;
  logic [31:0] din8;
  logic [7:0]  dout8;
  logic [1:0]  chan8;
  logic        sync4, en4, rdy4, valid4, busy4, ov4;
  logic [31:0] din4;
  logic [7:0]  dout4;
  logic [1:0]  chan4;
`ifdef SNAP_READOUT_SCHED_LAST_EN
  logic        last8, last4;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  snap_readout_sched #(.NCHAN(4), .WIDTH(8), .PERIOD(8)) u8 (
    .clk(clk), .rst_n(rst_n), .sync(sync8), .en(en8), .din(din8),
    .dout(dout8), .dout_chan(chan8), .dout_valid(valid8), .dout_ready(rdy8),
    .busy(busy8), .overrun(ov8)
`ifdef SNAP_READOUT_SCHED_LAST_EN
    , .dout_last(last8)
`endif
  );

  snap_readout_sched #(.NCHAN(4), .WIDTH(8), .PERIOD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .sync(sync4), .en(en4), .din(din4),
    .dout(dout4), .dout_chan(chan4), .dout_valid(valid4), .dout_ready(rdy4),
    .busy(busy4), .overrun(ov4)
`ifdef SNAP_READOUT_SCHED_LAST_EN
    , .dout_last(last4)
`endif
  );

  typedef struct {
    logic        sync;
    logic        en;
    logic [31:0] din;
    logic        rdy;
    logic        v;
    logic [7:0]  dout;
    logic [1:0]  chan;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic e, input logic [31:0] d, input logic r,
                     input logic v, input logic [7:0] o, input logic [1:0] c, input logic ov);
    vec_t t;
    t.sync = s; t.en = e; t.din = d; t.rdy = r;
    t.v = v; t.dout = o; t.chan = c; t.ov = ov;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[k*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sync8 = 1'b0; en8 = 1'b0; rdy8 = 1'b0; din8 = '0;
    sync4 = 1'b0; en4 = 1'b0; rdy4 = 1'b0; din4 = '0;

    // Each row: inputs applied before an edge, outputs expected just after it.
    add(0,0,D1,1, 0,8'h00,0,0);
    add(1,1,D1,1, 0,8'h00,0,0);                          // sync edge e
    add(0,1,D1,1, 1,8'h11,0,0);                          // capture at e+1
    add(0,1,D1,1, 1,8'h22,1,0);
    add(0,1,D1,1, 1,8'h33,2,0);
    add(0,1,D1,1, 1,8'h44,3,0);
    for (int i = 0; i < 4; i++) add(0,1,D2,1, 0,8'h00,0,0);
    add(0,1,D2,1, 1,8'h55,0,0);                          // period capture
    add(0,1,D2,1, 1,8'h66,1,0);
    for (int i = 0; i < 3; i++) add(0,1,D2,0, 1,8'h66,1,0);  // backpressure on chan 1
    add(0,1,D2,1, 1,8'h77,2,0);
    add(0,1,D2,1, 1,8'h88,3,0);
    add(0,1,D1,1, 0,8'h00,0,0);
    for (int i = 0; i < 2; i++) add(0,1,D1,0, 1,8'h11,0,0);
    for (int i = 0; i < 6; i++) add(0,1,D2,0, 1,8'h11,0,0);
    for (int i = 0; i < 2; i++) add(0,1,D2,0, 1,8'h11,0,1);  // dropped capture
    add(1,1,D2,0, 0,8'h00,0,0);                          // sync clears overrun
    add(0,1,D2,1, 1,8'h55,0,0);
    add(0,1,D2,1, 1,8'h66,1,0);
    add(0,0,D2,1, 1,8'h77,2,0);                          // en drops mid-drain
    add(0,0,D2,1, 1,8'h88,3,0);
    for (int i = 0; i < 24; i++) add(0,0,D1,1, 0,8'h00,0,0);
    for (int i = 0; i < 4; i++) add(0,1,D1,1, 0,8'h00,0,0);
    add(0,1,D1,1, 1,8'h11,0,0);                          // next boundary after re-enable

    #2;
    chk("reset valid", valid8, 0);
    chk("reset busy", busy8, 0);
    chk("reset overrun", ov8, 0);
    chk("reset dout", dout8, 0);
    chk("reset chan", chan8, 0);
    step();
    step();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      sync8 = tbl[i].sync; en8 = tbl[i].en; din8 = tbl[i].din; rdy8 = tbl[i].rdy;
      step();
      chk($sformatf("r%0d valid", i), valid8, tbl[i].v);
      chk($sformatf("r%0d busy", i), busy8, tbl[i].v);
      chk($sformatf("r%0d overrun", i), ov8, tbl[i].ov);
      if (tbl[i].v) begin
        chk($sformatf("r%0d dout", i), dout8, tbl[i].dout);
        chk($sformatf("r%0d chan", i), chan8, tbl[i].chan);
      end
`ifdef SNAP_READOUT_SCHED_LAST_EN
      chk($sformatf("r%0d last", i), last8, tbl[i].v && tbl[i].chan == 2'd3);
`endif
    end

    // Stall the drain into the next capture so overrun is set, then reset asynchronously.
    rdy8 = 1'b0; en8 = 1'b1; din8 = D2;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("stall overrun", ov8, 0);
      chk("stall dout", dout8, 8'h11);
    end
    step();
    chk("pre-reset overrun", ov8, 1);
    chk("pre-reset valid", valid8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst dout", dout8, 0);
    chk("async rst valid", valid8, 0);
    chk("async rst busy", busy8, 0);
    chk("async rst overrun", ov8, 0);
    chk("async rst chan", chan8, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rdy8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("post-rst idle %0d", k), valid8, 0);
    end
    step();
    chk("post-rst capture valid", valid8, 1);
    chk("post-rst capture dout", dout8, 8'h55);
    chk("post-rst capture chan", chan8, 0);

    // Back-to-back drains with PERIOD=4: final beat meets the next capture every time.
    en4 = 1'b1; rdy4 = 1'b1; din4 = D1; sync4 = 1'b1;
    step();
    chk("b2b sync valid", valid4, 0);
    sync4 = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      int g;
      int c;
      logic [31:0] snap;
      din4 = (((j - 1) / 4) % 2 == 1) ? D2 : D1;
      step();
      g = (j - 1) / 4;
      c = (j - 1) % 4;
      snap = (g % 2 == 1) ? D2 : D1;
      chk($sformatf("b2b %0d valid", j), valid4, 1);
      chk($sformatf("b2b %0d chan", j), chan4, c);
      chk($sformatf("b2b %0d dout", j), dout4, byte_of(snap, c));
      chk($sformatf("b2b %0d overrun", j), ov4, 0);
`ifdef SNAP_READOUT_SCHED_LAST_EN
      chk($sformatf("b2b %0d last", j), last4, c == 3);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
